dcache_controller: RTL and testbench
====================================

DCACHE_CONTROLLER -- requirements
Module: dcache_controller

Interface
REQ-001 Parameter INDEX_BITS, default 2: number of index bits; the cache has 2**INDEX_BITS lines.
REQ-002 Parameter OFFSET_BITS, default 4: byte-offset bits per line (16-byte line); tag = addr[15:INDEX_BITS+OFFSET_BITS].
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ldSt_enable  input  2  access type: 00 none, 01 load, 10 store, 11 treated as none.
REQ-006 addr  input  16  byte address of the access (the tlb_result of the memory stage).
REQ-007 stall  output  1  high = hold the cache pipeline register (drives enable_cache low).
REQ-008 hit  output  1  high when a valid access hits in IDLE.
REQ-009 array_index  output  INDEX_BITS  data-array line select.
REQ-010 array_we  output  1  store-hit word write strobe to the data array.
REQ-011 fill_we  output  1  one-cycle strobe writing the memory line into the data array.
REQ-012 mem_req  output  1  memory line request, held until accepted.
REQ-013 mem_we  output  1  1 = write-back of victim line, 0 = line read.
REQ-014 mem_addr  output  16  line-aligned memory address (offset bits zero).
REQ-015 mem_ack  input  1  one-cycle completion pulse from memory.

Function
REQ-016 Storage: per line, a valid bit, a dirty bit and a tag; direct-mapped, write-back, write-allocate.
REQ-017 States: IDLE, WRITEBACK, REFILL, COMPLETE; encoding is free.
REQ-018 Lookup in IDLE is combinational: hit = access valid AND valid[index] AND tag match.
REQ-019 array_index = addr index bits in every state (addr is held stable by the stall).
REQ-020 IDLE, no access: stall=0, hit=0, no strobes, state stays IDLE.
REQ-021 IDLE, load hit: stall=0, hit=1, no state change.
REQ-022 IDLE, store hit: stall=0, hit=1, array_we=1 same cycle; dirty[index] set at the edge.
REQ-023 IDLE, miss with victim valid AND dirty: stall=1; next state WRITEBACK, mem_req=1, mem_we=1, mem_addr={victim tag, index, zero offset}.
REQ-024 IDLE, miss otherwise: stall=1; next state REFILL, mem_req=1, mem_we=0, mem_addr={addr tag, index, zero offset}.
REQ-025 mem_req, mem_we and mem_addr are registered and stay constant until the edge sampling mem_ack=1.
REQ-026 WRITEBACK + mem_ack: clear dirty[index]; next REFILL with mem_we=0 and the new line address; mem_req stays 1.
REQ-027 REFILL + mem_ack: fill_we=1 that cycle; at the edge write tag, set valid, clear dirty; mem_req=0; next COMPLETE.
REQ-028 COMPLETE: stall=1, hit=0; a store sets dirty[index] and pulses array_we; next IDLE, where the held access hits.
REQ-029 stall=1 in every non-IDLE state; miss-to-release latency = memory waits + 2 cycles (clean) or + 3 cycles (dirty).
REQ-030 mem_ack outside WRITEBACK/REFILL is ignored.
REQ-031 ldSt_enable changing while state != IDLE is ignored; the access captured at the miss completes.

Reset
REQ-032 reset=1 at an edge: state IDLE, all valid and dirty bits 0, mem_req=0, mem_we=0, mem_addr=0; it overrides every other event, including mem_ack in the same cycle.
REQ-033 While reset is high and no access is presented: stall=0, hit=0, array_we=0, fill_we=0.
REQ-034 Reset during WRITEBACK/REFILL abandons the transaction; no fill_we is issued and no tag is written.

Verification
REQ-035 After reset, load 0x0040 -> stall=1, mem_req=1, mem_we=0, mem_addr=0x0040; ack after 3 cycles -> fill_we pulse, COMPLETE, then hit=1, stall=0.
REQ-036 Load 0x0042 after REQ-035 -> hit=1, stall=0 same cycle, no mem_req.
REQ-037 Store 0x0044 (hit) -> array_we=1 one cycle, then load 0x0440 (same index 0, new tag) -> mem_req with mem_we=1, mem_addr=0x0040, then mem_we=0, mem_addr=0x0440.
REQ-038 Spurious mem_ack pulses in IDLE and ldSt_enable=11 -> no state change, stall=0, hit=0.
REQ-039 Assert reset during REFILL with mem_ack the same cycle -> IDLE, mem_req=0, no fill_we; repeat load 0x0040 -> miss.
REQ-040 Store miss 0x0080 on clean index 0 -> REFILL, COMPLETE pulses array_we; a later conflicting miss writes back 0x0080.

Source files
------------

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data-cache controller.
// Holds the per-line valid/dirty/tag state and sequences memory write-back and refill.
module dcache_controller #(
    parameter int unsigned INDEX_BITS  = 2,
    parameter int unsigned OFFSET_BITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            ldSt_enable,
    input  logic [15:0]           addr,
    output logic                  stall,
    output logic                  hit,
    output logic [INDEX_BITS-1:0] array_index,
    output logic                  array_we,
    output logic                  fill_we,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [15:0]           mem_addr,
    input  logic                  mem_ack
);

    localparam int unsigned LINES = 2 ** INDEX_BITS;
    localparam int unsigned TAG_W = 16 - INDEX_BITS - OFFSET_BITS;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2,
        COMPLETE  = 2'd3
    } state_t;

    state_t             state_q;
    logic [LINES-1:0]   valid_q;
    logic [LINES-1:0]   dirty_q;
    logic [TAG_W-1:0]   tag_q [LINES];
    logic               store_q;
    logic               mem_req_q;
    logic               mem_we_q;
    logic [15:0]        mem_addr_q;

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_W-1:0]      addr_tag;
    logic                  is_load;
    logic                  is_store;
    logic                  access;
    logic                  lookup_hit;
    logic [15:0]           line_addr;
    logic [15:0]           victim_addr;

    assign idx         = addr[OFFSET_BITS +: INDEX_BITS];
    assign addr_tag    = addr[15 -: TAG_W];
    assign is_load     = (ldSt_enable == 2'b01);
    assign is_store    = (ldSt_enable == 2'b10);
    assign access      = is_load | is_store;
    assign lookup_hit  = access && valid_q[idx] && (tag_q[idx] == addr_tag);
    assign line_addr   = {addr_tag, idx, {OFFSET_BITS{1'b0}}};
    assign victim_addr = {tag_q[idx], idx, {OFFSET_BITS{1'b0}}};

    assign array_index = idx;
    assign hit         = (state_q == IDLE) && lookup_hit;
    assign stall       = (state_q != IDLE) || (access && !lookup_hit);
    // Store strobes come from the live request in IDLE but from the captured one in COMPLETE.
    assign array_we    = !reset && (((state_q == IDLE) && is_store && lookup_hit)
                                    || ((state_q == COMPLETE) && store_q));
    assign fill_we     = !reset && (state_q == REFILL) && mem_ack;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            dirty_q    <= '0;
            store_q    <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (lookup_hit) begin
                        if (is_store) dirty_q[idx] <= 1'b1;
                    end else if (access) begin
                        store_q   <= is_store;
                        mem_req_q <= 1'b1;
                        if (valid_q[idx] && dirty_q[idx]) begin
                            state_q    <= WRITEBACK;
                            mem_we_q   <= 1'b1;
                            mem_addr_q <= victim_addr;
                        end else begin
                            state_q    <= REFILL;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= line_addr;
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_ack) begin
                        dirty_q[idx] <= 1'b0;
                        mem_we_q     <= 1'b0;
                        mem_addr_q   <= line_addr;
                        state_q      <= REFILL;
                    end
                end
                REFILL: begin
                    if (mem_ack) begin
                        tag_q[idx]   <= addr_tag;
                        valid_q[idx] <= 1'b1;
                        dirty_q[idx] <= 1'b0;
                        mem_req_q    <= 1'b0;
                        state_q      <= COMPLETE;
                    end
                end
                COMPLETE: begin
                    if (store_q) dirty_q[idx] <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed self-checking bench for dcache_controller (default 4 lines x 16 bytes).
module tb_dcache_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  ldSt_enable;
    logic [15:0] addr;
    logic        stall;
    logic        hit;
    logic [1:0]  array_index;
    logic        array_we;
    logic        fill_we;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic        mem_ack;

    int unsigned tests  = 0;
    int unsigned failed = 0;

    dcache_controller #(.INDEX_BITS(2), .OFFSET_BITS(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .ldSt_enable (ldSt_enable),
        .addr        (addr),
        .stall       (stall),
        .hit         (hit),
        .array_index (array_index),
        .array_we    (array_we),
        .fill_we     (fill_we),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; ldSt_enable = 2'b00; addr = 16'h0000; mem_ack = 1'b0;
        step(); step();
        chk("rst_stall", 16'(stall), 16'd0);
        chk("rst_hit", 16'(hit), 16'd0);
        chk("rst_array_we", 16'(array_we), 16'd0);
        chk("rst_fill_we", 16'(fill_we), 16'd0);
        chk("rst_mem_req", 16'(mem_req), 16'd0);
        chk("rst_mem_we", 16'(mem_we), 16'd0);
        chk("rst_mem_addr", mem_addr, 16'h0000);

        // Cold load miss 0x0040 -> refill after 3 wait cycles
        reset = 1'b0; ldSt_enable = 2'b01; addr = 16'h0040; #1;
        chk("cold_stall", 16'(stall), 16'd1);
        chk("cold_hit", 16'(hit), 16'd0);
        chk("cold_index", 16'(array_index), 16'd0);
        step();
        chk("rf_req", 16'(mem_req), 16'd1);
        chk("rf_we", 16'(mem_we), 16'd0);
        chk("rf_addr", mem_addr, 16'h0040);
        chk("rf_stall", 16'(stall), 16'd1);
        step(); step();
        chk("rf_wait_req", 16'(mem_req), 16'd1);
        chk("rf_wait_fill", 16'(fill_we), 16'd0);
        step();
        mem_ack = 1'b1; #1;
        chk("rf_fill_we", 16'(fill_we), 16'd1);
        step();
        mem_ack = 1'b0;
        chk("cmp_req", 16'(mem_req), 16'd0);
        chk("cmp_stall", 16'(stall), 16'd1);
        chk("cmp_hit", 16'(hit), 16'd0);
        chk("cmp_fill_we", 16'(fill_we), 16'd0);
        chk("cmp_array_we", 16'(array_we), 16'd0);
        step();
        chk("post_hit", 16'(hit), 16'd1);
        chk("post_stall", 16'(stall), 16'd0);

        // Same-line load hit
        addr = 16'h0042; #1;
        chk("ld_hit", 16'(hit), 16'd1);
        chk("ld_hit_stall", 16'(stall), 16'd0);
        step();
        chk("ld_hit_noreq", 16'(mem_req), 16'd0);

        // Store hit, then conflicting load forces write-back of 0x0040
        ldSt_enable = 2'b10; addr = 16'h0044; #1;
        chk("st_hit", 16'(hit), 16'd1);
        chk("st_array_we", 16'(array_we), 16'd1);
        chk("st_stall", 16'(stall), 16'd0);
        step();
        ldSt_enable = 2'b01; addr = 16'h0440; #1;
        chk("conf_stall", 16'(stall), 16'd1);
        chk("conf_hit", 16'(hit), 16'd0);
        chk("conf_array_we", 16'(array_we), 16'd0);
        step();
        chk("wb_req", 16'(mem_req), 16'd1);
        chk("wb_we", 16'(mem_we), 16'd1);
        chk("wb_addr", mem_addr, 16'h0040);
        mem_ack = 1'b1; #1;
        chk("wb_no_fill", 16'(fill_we), 16'd0);
        step();
        mem_ack = 1'b0;
        chk("wb2rf_req", 16'(mem_req), 16'd1);
        chk("wb2rf_we", 16'(mem_we), 16'd0);
        chk("wb2rf_addr", mem_addr, 16'h0440);
        mem_ack = 1'b1; #1;
        chk("wb2rf_fill", 16'(fill_we), 16'd1);
        step();
        mem_ack = 1'b0;
        chk("conf_cmp_stall", 16'(stall), 16'd1);
        step();
        chk("conf_post_hit", 16'(hit), 16'd1);
        chk("conf_post_stall", 16'(stall), 16'd0);

        // Spurious ack in IDLE and reserved access encoding
        ldSt_enable = 2'b00; mem_ack = 1'b1; #1;
        chk("spur_stall", 16'(stall), 16'd0);
        chk("spur_hit", 16'(hit), 16'd0);
        step();
        mem_ack = 1'b0;
        chk("spur_req", 16'(mem_req), 16'd0);
        ldSt_enable = 2'b11; #1;
        chk("ls11_stall", 16'(stall), 16'd0);
        chk("ls11_hit", 16'(hit), 16'd0);
        chk("ls11_array_we", 16'(array_we), 16'd0);
        step();
        chk("ls11_req", 16'(mem_req), 16'd0);

        // Reset during refill with simultaneous ack
        ldSt_enable = 2'b01; addr = 16'h0040; #1;
        chk("rr_miss_stall", 16'(stall), 16'd1);
        step();
        chk("rr_req", 16'(mem_req), 16'd1);
        chk("rr_addr", mem_addr, 16'h0040);
        reset = 1'b1; mem_ack = 1'b1; #1;
        chk("rr_no_fill", 16'(fill_we), 16'd0);
        step();
        reset = 1'b0; mem_ack = 1'b0; #1;
        chk("rr_req_clr", 16'(mem_req), 16'd0);
        chk("rr_addr_clr", mem_addr, 16'h0000);
        chk("rr_remiss_stall", 16'(stall), 16'd1);
        chk("rr_remiss_hit", 16'(hit), 16'd0);
        step();
        chk("rr_remiss_req", 16'(mem_req), 16'd1);
        chk("rr_remiss_addr", mem_addr, 16'h0040);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        step();
        chk("rr_post_hit", 16'(hit), 16'd1);

        // Store miss on clean line; access change mid-refill must be ignored
        ldSt_enable = 2'b10; addr = 16'h0080; #1;
        chk("sm_stall", 16'(stall), 16'd1);
        chk("sm_hit", 16'(hit), 16'd0);
        step();
        chk("sm_we", 16'(mem_we), 16'd0);
        chk("sm_addr", mem_addr, 16'h0080);
        ldSt_enable = 2'b01;
        mem_ack = 1'b1; #1;
        chk("sm_fill", 16'(fill_we), 16'd1);
        step();
        mem_ack = 1'b0; #1;
        chk("sm_cmp_array_we", 16'(array_we), 16'd1);
        chk("sm_cmp_stall", 16'(stall), 16'd1);
        chk("sm_cmp_hit", 16'(hit), 16'd0);
        ldSt_enable = 2'b10;
        step();
        chk("sm_post_hit", 16'(hit), 16'd1);
        chk("sm_post_stall", 16'(stall), 16'd0);
        step();
        ldSt_enable = 2'b01; addr = 16'h00C0; #1;
        chk("sm_conf_stall", 16'(stall), 16'd1);
        step();
        chk("sm_wb_we", 16'(mem_we), 16'd1);
        chk("sm_wb_addr", mem_addr, 16'h0080);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("sm_rf_we", 16'(mem_we), 16'd0);
        chk("sm_rf_addr", mem_addr, 16'h00C0);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        step();
        chk("sm_final_hit", 16'(hit), 16'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
